imem_loader: RTL and testbench

- Writer side of the instruction memory: receives a framed byte stream from a host link and writes it into the byte-wide instruction memory write port.
- Bytes land at consecutive byte addresses starting at BASE_ADDR, so the fetch side reads them back as little-endian 32-bit words.
- Holds the core in reset (cpu_hold) while a program is loading and releases it only after a checksum-verified load.

---
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: parses MAGIC/LEN/payload/CSUM frames from a byte
// stream, writes the payload into the byte-wide imem port, gates cpu_hold.
module imem_loader #(
    parameter int unsigned       ADDR_W        = 64,
    parameter int unsigned       MEM_BYTES     = 132,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
    parameter logic [7:0]        MAGIC         = 8'hA5,
    parameter logic              HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic              err_csum,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MEM_BYTES);

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        sum_q, sum_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_d;
    logic              busy_d, done_d, err_len_d, err_csum_d, hold_d;
    logic              xfer;
    logic [15:0]       len;

    assign xfer = s_valid & s_ready;
    assign len  = {s_data, len_lo_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            len_lo_q  <= '0;
            cnt_q     <= '0;
            ptr_q     <= BASE_ADDR;
            sum_q     <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_len   <= 1'b0;
            err_csum  <= 1'b0;
            cpu_hold  <= HOLD_AT_RESET;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            sum_q     <= sum_d;
            s_ready   <= 1'b1;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            busy      <= busy_d;
            done      <= done_d;
            err_len   <= err_len_d;
            err_csum  <= err_csum_d;
            cpu_hold  <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        sum_d      = sum_q;
        we_d       = 1'b0;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        done_d     = done;
        err_len_d  = err_len;
        err_csum_d = err_csum;
        hold_d     = cpu_hold;
        if (xfer) begin
            unique case (state_q)
                IDLE: begin
                    if (s_data == MAGIC) begin
                        state_d    = LEN_LO;
                        done_d     = 1'b0;
                        err_len_d  = 1'b0;
                        err_csum_d = 1'b0;
                        hold_d     = 1'b1;
                        sum_d      = '0;
                    end
                end
                LEN_LO: begin
                    len_lo_d = s_data;
                    state_d  = LEN_HI;
                end
                LEN_HI: begin
                    if (len == 16'd0 || {1'b0, len} > MAX_LEN) begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d   = len;
                        ptr_d   = BASE_ADDR;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = s_data;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    sum_d   = sum_q + s_data;
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = CSUM;
                end
                CSUM: begin
                    if (s_data == sum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_csum_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // busy tracks the state register it is loaded alongside
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level model builds per-byte
// expected output snapshots; a negedge process compares every cycle.
module tb_imem_loader;

    localparam logic [7:0] MAGIC = 8'hA5;
    localparam int         MEMB  = 132;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] d;
        bit         we;
        int         addr;
        bit         busy;
        bit         done;
        bit         el;
        bit         ec;
        bit         hold;
    } step_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy, done, err_len, err_csum, cpu_hold;

    int          checks = 0;
    int          errors = 0;
    bit          run = 0;
    bit          exp_ready = 0;
    step_t       cur;
    step_t       steps[$];
    bit          m_done, m_el, m_ec, m_hold;
    logic [15:0] wlog[$];

    imem_loader dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .err_len  (err_len),
        .err_csum (err_csum),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (mem_we === 1'b1) wlog.push_back({mem_addr[7:0], mem_wdata});
        if (run) begin
            chk("s_ready", s_ready, exp_ready);
            chk("mem_we", mem_we, cur.we);
            if (cur.we) begin
                chk("mem_addr", mem_addr, 64'(cur.addr));
                chk("mem_wdata", mem_wdata, cur.d);
            end
            chk("busy", busy, cur.busy);
            chk("done", done, cur.done);
            chk("err_len", err_len, cur.el);
            chk("err_csum", err_csum, cur.ec);
            chk("cpu_hold", cpu_hold, cur.hold);
        end
    end

    function automatic step_t mk(logic [7:0] d, bit we, int addr, bit b);
        step_t s;
        s.d = d; s.we = we; s.addr = addr; s.busy = b;
        s.done = m_done; s.el = m_el; s.ec = m_ec; s.hold = m_hold;
        return s;
    endfunction

    task automatic build(input bq_t garb, input bq_t pay, input int n,
                         input logic [7:0] cs);
        logic [7:0] sum = 8'h00;
        foreach (garb[i]) steps.push_back(mk(garb[i], 0, 0, 0));
        m_done = 0; m_el = 0; m_ec = 0; m_hold = 1;
        steps.push_back(mk(MAGIC, 0, 0, 1));
        steps.push_back(mk(n[7:0], 0, 0, 1));
        if (n == 0 || n > MEMB) begin
            m_el = 1;
            steps.push_back(mk(n[15:8], 0, 0, 0));
            return;
        end
        steps.push_back(mk(n[15:8], 0, 0, 1));
        foreach (pay[i]) begin
            steps.push_back(mk(pay[i], 1, i, 1));
            sum = sum + pay[i];
        end
        if (cs == sum) begin
            m_done = 1; m_hold = 0;
        end else begin
            m_ec = 1;
        end
        steps.push_back(mk(cs, 0, 0, 0));
    endtask

    task automatic cycle(input bit v, input step_t s);
        s_valid = v;
        s_data  = v ? s.d : 8'($urandom);
        @(posedge clk);
        #1;
        exp_ready = 1;
        if (v) cur = s;
        else cur.we = 0;
    endtask

    task automatic send(input int n, input int gmode);
        step_t s;
        for (int i = 0; i < n; i++) begin
            int g = (gmode < 0) ? $urandom_range(0, 2) : gmode;
            for (int j = 0; j < g; j++) cycle(0, cur);
            s = steps.pop_front();
            cycle(1, s);
        end
        s_valid = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        steps.delete();
        m_done = 0; m_el = 0; m_ec = 0; m_hold = 1;
        cur = mk(8'h00, 0, 0, 0);
        exp_ready = 0;
        s_valid = 0;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {done, err_len, err_csum}, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        run = 1;
        repeat (2) @(posedge clk);
        #2 reset_n = 1;
        cycle(0, cur);
    endtask

    function automatic bq_t rnd_bytes(int n, bit no_magic);
        bq_t q;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b = 8'($urandom);
            if (no_magic && b == MAGIC) b = 8'h00;
            q.push_back(b);
        end
        return q;
    endfunction

    initial begin
        bq_t none, p;
        none = {};
        #1;
        do_reset();

        // good frame, back-to-back
        wlog.delete();
        p = {8'h93, 8'h02, 8'h00, 8'h00};
        build(none, p, 4, 8'h95);
        send(steps.size(), 0);
        chk("good_model_done", m_done, 1);
        chk("good_done", done, 1);
        chk("good_hold", cpu_hold, 0);
        chk("good_busy", busy, 0);
        chk("good_nwr", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("good_wr0", wlog[0], 16'h0093);
            chk("good_wr1", wlog[1], 16'h0102);
            chk("good_wr2", wlog[2], 16'h0200);
            chk("good_wr3", wlog[3], 16'h0300);
        end

        // checksum error
        wlog.delete();
        build(none, p, 4, 8'h96);
        send(steps.size(), 0);
        chk("csum_model_ec", m_ec, 1);
        chk("csum_err", err_csum, 1);
        chk("csum_done", done, 0);
        chk("csum_hold", cpu_hold, 1);
        chk("csum_nwr", wlog.size(), 4);

        // length error, then MAGIC clears it
        wlog.delete();
        build(none, none, 133, 8'h00);
        send(steps.size(), 0);
        chk("len_err", err_len, 1);
        chk("len_hold", cpu_hold, 1);
        chk("len_nwr", wlog.size(), 0);
        p = {8'h10, 8'h20, 8'h30};
        build(none, p, 3, 8'h60);
        send(1, 0);
        chk("magic_clr_len", err_len, 0);
        chk("magic_busy", busy, 1);
        send(steps.size(), 0);
        chk("len_follow_done", done, 1);

        // leading garbage and toggling valid
        wlog.delete();
        build({8'h11, 8'h22}, {8'hFF, 8'h01}, 2, 8'h00);
        send(steps.size(), 1);
        chk("gap_done", done, 1);
        chk("gap_nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("gap_wr0", wlog[0], 16'h00FF);
            chk("gap_wr1", wlog[1], 16'h0101);
        end

        // reset in the middle of DATA
        build(none, {8'h01, 8'h02, 8'h03, 8'h04}, 4, 8'h0A);
        send(5, 0);
        #2;
        do_reset();
        build(none, {8'hA5, 8'h5A}, 2, 8'hFF);
        send(steps.size(), 0);
        chk("post_rst_done", done, 1);
        chk("post_rst_hold", cpu_hold, 0);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            int n;
            logic [7:0] cs;
            bq_t g = rnd_bytes($urandom_range(0, 2), 1);
            if ($urandom_range(0, 9) == 0) begin
                n = $urandom_range(0, 1) ? 0 : $urandom_range(133, 65535);
                build(g, none, n, 8'h00);
            end else begin
                case ($urandom_range(0, 5))
                    0: n = 1;
                    1: n = MEMB;
                    default: n = $urandom_range(1, MEMB);
                endcase
                p = rnd_bytes(n, 0);
                cs = 8'h00;
                foreach (p[i]) cs = cs + p[i];
                if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
                build(g, p, n, cs);
            end
            send(steps.size(), -1);
        end
        repeat (3) cycle(0, cur);

        run = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
